// File: rtl/power_spectrum_if.sv
// Stream bundle between the FFT output, the power stage and the mel filterbank.
interface power_spectrum_if #(
  parameter int unsigned I_BW = 16,
  parameter int unsigned O_BW = 32
);
  logic                   en_i;
  logic signed [I_BW-1:0] data_real_i;
  logic signed [I_BW-1:0] data_imag_i;
  logic                   valid_i;
  logic                   last_i;
  logic [O_BW-1:0]        data_o;
  logic                   valid_o;
  logic                   last_o;
  logic                   err_o;

  // Upstream side: drives the FFT bins, observes the power stream.
  modport master (
    output en_i, data_real_i, data_imag_i, valid_i, last_i,
    input  data_o, valid_o, last_o, err_o
  );

  // Power stage side.
  modport slave (
    input  en_i, data_real_i, data_imag_i, valid_i, last_i,
    output data_o, valid_o, last_o, err_o
  );
endinterface

// File: rtl/power_spectrum.sv
// Power spectrum |X[k]|^2 for bins 0..OUT_LEN-1 of a streamed FFT frame,
// two-stage pipeline, mirror half consumed and discarded.
module power_spectrum #(
  parameter int unsigned I_BW    = 16,
  parameter int unsigned O_BW    = 32,
  parameter int unsigned FFT_LEN = 256,
  parameter int unsigned OUT_LEN = 129,
  parameter int unsigned CNT_BW  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  power_spectrum_if.slave   bus
);

  localparam int unsigned SQ_BW  = 2 * I_BW - 1;
  localparam int unsigned SUM_BW = 2 * I_BW;
  localparam logic [CNT_BW-1:0] CNT_MAX  = CNT_BW'(FFT_LEN - 1);
  localparam logic [CNT_BW-1:0] LAST_OUT = CNT_BW'(OUT_LEN - 1);

  logic [CNT_BW-1:0] cnt;
  logic [CNT_BW-1:0] cnt_nxt_c;
  logic              err_set_c;
  logic              accept_c;
  logic              pass_c;
  logic              is_last_out_c;

  logic signed [SQ_BW-1:0] ext_re_c;
  logic signed [SQ_BW-1:0] ext_im_c;
  logic signed [SQ_BW-1:0] prod_re_c;
  logic signed [SQ_BW-1:0] prod_im_c;
  logic [SQ_BW-1:0]        sq_re_c;
  logic [SQ_BW-1:0]        sq_im_c;

  logic              s1_valid;
  logic              s1_last;
  logic [SQ_BW-1:0]  s1_sq_re;
  logic [SQ_BW-1:0]  s1_sq_im;
  logic [SUM_BW-1:0] sum_c;

  // Bin acceptance, pass window and frame-length checking.
  always_comb begin
    accept_c      = bus.valid_i & bus.en_i;
    pass_c        = (cnt <= LAST_OUT);
    is_last_out_c = (cnt == LAST_OUT);
    cnt_nxt_c     = cnt;
    err_set_c     = 1'b0;
    if (accept_c) begin
      if (bus.last_i && (cnt != CNT_MAX)) begin
        // Short frame: restart at bin 0.
        err_set_c = 1'b1;
        cnt_nxt_c = '0;
      end else begin
        // Final bin without last_i flags a long frame but wraps normally.
        err_set_c = (cnt == CNT_MAX) && !bus.last_i;
        cnt_nxt_c = (cnt == CNT_MAX) ? '0 : cnt + CNT_BW'(1);
      end
    end
  end

  // Squares; the operands are sign-extended so the product is exact
  // modulo 2^SQ_BW, and a square never exceeds 2^(2*I_BW-2).
  always_comb begin
    ext_re_c  = SQ_BW'(bus.data_real_i);
    ext_im_c  = SQ_BW'(bus.data_imag_i);
    prod_re_c = ext_re_c * ext_re_c;
    prod_im_c = ext_im_c * ext_im_c;
    sq_re_c   = $unsigned(prod_re_c);
    sq_im_c   = $unsigned(prod_im_c);
    sum_c     = SUM_BW'(s1_sq_re) + SUM_BW'(s1_sq_im);
  end

  // Bin counter and sticky error flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt       <= '0;
      bus.err_o <= 1'b0;
    end else if (!bus.en_i) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt_c;
      if (err_set_c) begin
        bus.err_o <= 1'b1;
      end
    end
  end

  // Stage 1 control: pass and last-output flags travel with the squares.
  always_ff @(posedge clk_i) begin
    if (rst_i || !bus.en_i) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
    end else begin
      s1_valid <= accept_c & pass_c;
      s1_last  <= accept_c & is_last_out_c;
    end
  end

  // Stage 1 datapath: squares captured only for accepted bins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_sq_re <= '0;
      s1_sq_im <= '0;
    end else if (accept_c) begin
      s1_sq_re <= sq_re_c;
      s1_sq_im <= sq_im_c;
    end
  end

  // Stage 2: summed power with its valid/last; data holds while idle.
  always_ff @(posedge clk_i) begin
    if (rst_i || !bus.en_i) begin
      bus.data_o  <= '0;
      bus.valid_o <= 1'b0;
      bus.last_o  <= 1'b0;
    end else begin
      bus.valid_o <= s1_valid;
      bus.last_o  <= s1_last;
      if (s1_valid) begin
        bus.data_o <= O_BW'(sum_c);
      end
    end
  end

endmodule

// File: tb/tb_power_spectrum.sv
// Directed bench for power_spectrum with a fixed-latency expected-output queue.
module tb_power_spectrum;

  typedef struct packed {
    logic        v;
    logic        l;
    logic [31:0] d;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   out_cnt;
  int   last_cnt;
  int   mcnt;
  logic merr;
  exp_t q[$];

  power_spectrum_if #(.I_BW(16), .O_BW(32)) bus ();

  power_spectrum #(
    .I_BW(16), .O_BW(32), .FFT_LEN(256), .OUT_LEN(129), .CNT_BW(8)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Compare the outputs due this cycle against the oldest queued expectation.
  task automatic check_out();
    exp_t e;
    if (q.size() == 0) begin
      chk("sb_underflow", 32'd0, 32'd1);
      return;
    end
    e = q.pop_front();
    chk("valid_o", 32'(bus.valid_o), 32'(e.v));
    chk("last_o", 32'(bus.last_o), 32'(e.l));
    if (e.v) chk("data_o", bus.data_o, e.d);
    chk("err_o", 32'(bus.err_o), 32'(merr));
    if (bus.valid_o === 1'b1) out_cnt++;
    if (bus.last_o === 1'b1) last_cnt++;
  endtask

  // One cycle: check outputs, drive inputs, update the reference model.
  task automatic drive(input logic r, input logic e, input logic v, input logic l,
                       input logic signed [15:0] re, input logic signed [15:0] im);
    exp_t   x;
    longint p;
    @(negedge clk);
    check_out();
    rst             = r;
    bus.en_i        = e;
    bus.valid_i     = v;
    bus.last_i      = l;
    bus.data_real_i = re;
    bus.data_imag_i = im;
    x = '{v: 1'b0, l: 1'b0, d: 32'd0};
    if (r || !e) begin
      mcnt = 0;
      if (r) merr = 1'b0;
      for (int i = 0; i < q.size(); i++) q[i] = '{v: 1'b0, l: 1'b0, d: 32'd0};
    end else if (v) begin
      p   = longint'(re) * longint'(re) + longint'(im) * longint'(im);
      x.v = (mcnt <= 128);
      x.l = (mcnt == 128);
      x.d = 32'(p);
      if (l && mcnt != 255) begin
        merr = 1'b1;
        mcnt = 0;
      end else begin
        if (mcnt == 255 && !l) merr = 1'b1;
        mcnt = (mcnt + 1) % 256;
      end
    end
    q.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 16'sd0, 16'sd0);
  endtask

  // kind: 0 ramp (k,-k), 1 both -32768, 2 (32767,0), 3 random.
  task automatic send_bins(input int n, input int kind, input logic last_at_end);
    logic signed [15:0] re;
    logic signed [15:0] im;
    for (int k = 0; k < n; k++) begin
      case (kind)
        0: begin re = 16'(k); im = 16'(-k); end
        1: begin re = -16'sd32768; im = -16'sd32768; end
        2: begin re = 16'sd32767; im = 16'sd0; end
        default: begin re = 16'($urandom); im = 16'($urandom); end
      endcase
      drive(1'b0, 1'b1, 1'b1, last_at_end && (k == n - 1), re, im);
    end
  endtask

  task automatic chk_counts(input string tag, input int o0, input int l0,
                            input int exp_out, input int exp_last);
    chk({tag, "_outputs"}, 32'(out_cnt - o0), 32'(exp_out));
    chk({tag, "_lasts"}, 32'(last_cnt - l0), 32'(exp_last));
  endtask

  initial begin
    int o0;
    int l0;
    checks   = 0;
    failures = 0;
    out_cnt  = 0;
    last_cnt = 0;
    mcnt     = 0;
    merr     = 1'b0;
    rst             = 1'b1;
    bus.en_i        = 1'b0;
    bus.valid_i     = 1'b0;
    bus.last_i      = 1'b0;
    bus.data_real_i = '0;
    bus.data_imag_i = '0;
    q.push_back('{v: 1'b0, l: 1'b0, d: 32'd0});
    q.push_back('{v: 1'b0, l: 1'b0, d: 32'd0});

    // Reset state
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 16'sd0, 16'sd0);
    chk("reset_data_o", bus.data_o, 32'd0);
    chk("reset_valid_o", 32'(bus.valid_o), 32'd0);
    chk("reset_err_o", 32'(bus.err_o), 32'd0);
    idle(2);

    // Ramp frame: data = 2k^2, bin 128 = 32768
    o0 = out_cnt; l0 = last_cnt;
    send_bins(256, 0, 1'b1);
    idle(4);
    chk_counts("ramp", o0, l0, 129, 1);
    chk("ramp_err_o", 32'(bus.err_o), 32'd0);

    // Extreme values
    o0 = out_cnt; l0 = last_cnt;
    send_bins(256, 1, 1'b1);
    idle(3);
    send_bins(256, 2, 1'b1);
    idle(4);
    chk_counts("extreme", o0, l0, 258, 2);

    // Back-to-back random frames
    o0 = out_cnt; l0 = last_cnt;
    send_bins(256, 3, 1'b1);
    send_bins(256, 3, 1'b1);
    idle(4);
    chk_counts("b2b", o0, l0, 258, 2);
    chk("b2b_err_o", 32'(bus.err_o), 32'd0);

    // Short frame: last_i on bin 100, then a full frame
    o0 = out_cnt; l0 = last_cnt;
    send_bins(101, 3, 1'b1);
    @(posedge clk); #1;
    chk("short_err_o", 32'(bus.err_o), 32'd1);
    send_bins(256, 0, 1'b1);
    idle(4);
    chk_counts("short", o0, l0, 230, 1);

    // Reset at bin 50, then a fresh frame
    o0 = out_cnt; l0 = last_cnt;
    send_bins(50, 3, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 16'sd50, 16'sd50);
    @(posedge clk); #1;
    chk("rst_mid_valid_o", 32'(bus.valid_o), 32'd0);
    chk("rst_mid_err_o", 32'(bus.err_o), 32'd0);
    send_bins(256, 3, 1'b1);
    idle(4);
    chk_counts("rst_mid", o0, l0, 49 + 129, 1);

    // Missing last_i sets err_o; en_i drop at bin 60 must hold it
    o0 = out_cnt; l0 = last_cnt;
    send_bins(256, 0, 1'b0);
    idle(3);
    chk("long_err_o", 32'(bus.err_o), 32'd1);
    send_bins(60, 3, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'sd60, 16'sd60);
    @(posedge clk); #1;
    chk("en_drop_valid_o", 32'(bus.valid_o), 32'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'sd61, 16'sd61);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'sd62, 16'sd62);
    send_bins(256, 3, 1'b1);
    idle(4);
    chk_counts("en_drop", o0, l0, 129 + 59 + 129, 2);
    chk("en_drop_err_o", 32'(bus.err_o), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/power_spectrum.md
Name: power_spectrum

Overview:
- Streaming producer of the 129-bin power spectrum that drives the mel filterbank input.
- Consumes the complex 256-point FFT output stream, one bin per cycle, natural order.
- Emits re^2+im^2 for bins 0..128 and discards bins 129..255 (mirror half).
- Output is a contiguous valid run with last on bin 128, which meets the filterbank requirement that valid never deassert within a frame.

Parameters:
- I_BW, 16, signed bitwidth of each FFT component (real, imag).
- O_BW, 32, unsigned output bitwidth; must be at least 2*I_BW.
- FFT_LEN, 256, bins per input frame.
- OUT_LEN, 129, bins emitted per frame (FFT_LEN/2+1).
- CNT_BW, 8, bin counter width, clog2(FFT_LEN).

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- en_i  in  1  block enable; low = idle/flush.
- data_real_i  in  I_BW  signed real part of current bin.
- data_imag_i  in  I_BW  signed imaginary part of current bin.
- valid_i  in  1  input bin valid; contiguous within a frame.
- last_i  in  1  marks bin FFT_LEN-1 of a frame; qualified by valid_i.
- data_o  out  O_BW  unsigned power of current output bin.
- valid_o  out  1  output bin valid.
- last_o  out  1  marks output bin OUT_LEN-1; only high with valid_o.
- err_o  out  1  sticky frame-length error flag.

Behaviour:
- Reset (rst_i=1 at edge): data_o=0, valid_o=0, last_o=0, err_o=0, bin counter=0, pipeline valid bits cleared. Reset mid-frame abandons the frame; the next valid_i after reset is bin 0.
- en_i=0: same clearing as reset, except err_o holds. Outputs deassert on the next edge; in-flight bins are dropped.
- Bin counter cnt: increments on each accepted input (valid_i & en_i) and wraps FFT_LEN-1 -> 0.
- Pass condition: cnt <= OUT_LEN-1. Bins with cnt >= OUT_LEN are consumed but produce no output.
- Pipeline: 2 stages, fixed latency 2 cycles from input edge to output.
  - Stage 1 registers sq_re = re*re and sq_im = im*im, each unsigned 2*I_BW-1 bits, plus a pass bit and an is_last_out bit (cnt == OUT_LEN-1).
  - Stage 2 registers data_o = sq_re + sq_im, zero-extended to O_BW, together with valid_o and last_o.
- Arithmetic: exact, no saturation. Worst case is (-32768)^2 * 2 = 0x8000_0000, which fits in 32 bits unsigned.
- When valid_o=0, data_o holds its last value. It is not required to be zero; the bench checks data_o only when valid_o=1.
- Output run per frame: exactly OUT_LEN consecutive valid_o cycles, provided input bins 0..128 arrived contiguously.
- last_i checking:
  - last_i with cnt == FFT_LEN-1 is normal; the counter wraps to 0.
  - last_i with cnt != FFT_LEN-1 (short frame) sets err_o and forces cnt to 0 for the next bin. Outputs already in the pipeline still emerge.
  - cnt == FFT_LEN-1 without last_i (long/missing last) sets err_o and wraps the counter normally.
- err_o is sticky until rst_i. It does not stall or gate the datapath.
- Simultaneous events: rst_i dominates en_i, which dominates valid_i. last_i without valid_i is ignored.
- Gaps in valid_i between frames are allowed. Gaps within a frame are a protocol violation; a gap only delays counting and is not detected.
- No back-pressure: the downstream block is always ready.

Test Plan:
- Single frame, bin k has re=k, im=-k (k=0..255) -> 129 outputs, data_o=2k^2 (bin 128 = 32768), last_o only on bin 128, valid_o first high 2 cycles after bin 0, err_o=0.
- Extreme values, all bins re=-32768, im=-32768 -> data_o=0x8000_0000 on every output; re=32767, im=0 -> 0x3FFF_0001.
- Two back-to-back frames with no gap -> 258 outputs in two contiguous runs of 129 separated by 127 idle cycles; last_o pulses exactly twice.
- last_i asserted on bin 100 -> 101 outputs, err_o=1 from the next cycle; the following frame restarts at bin 0 and yields a full 129 outputs.
- rst_i pulsed at bin 50, then a fresh full frame -> valid_o=0 the cycle after reset, err_o=0, next frame yields 129 correct outputs.
- en_i dropped at bin 60 for 3 cycles, then a full frame with en_i=1 -> valid_o low within 1 cycle of the drop, no further outputs for the aborted frame, next frame correct, err_o unchanged.
